mem_arbiter: RTL and testbench

Shares one single-port, fixed-latency unified memory between the MIPS instruction-fetch port and the data (lw/sw) port. It sits between the CPU and the memory model. It serialises the two requesters, drives the memory command bus, and returns read data plus per-port stall signals. `if_stall` feeds the `~stall` enables of the IF/ID pipeline registers and the PC register.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arbiter_rr_pick.sv | 24 ++
 rtl/mem_arbiter.sv | 113 +++++++++++
 tb/tb_mem_arbiter.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DONE
   } arb_state_t;

   typedef enum logic {
      OWN_I,
      OWN_D
   } owner_t;

   localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational grant selection between the fetch and data ports.
// D wins a tie unless it won the previous arbitration.
module rr_pick
   import mem_arb_pkg::*;
(
   input  logic   if_req,
   input  logic   d_req,
   input  owner_t last,
   output owner_t grant,
   output logic   valid
);

   // Pick the grantee from the live requests and the previous winner.
   always_comb begin
      grant = OWN_I;
      valid = if_req | d_req;
      if (if_req && d_req) begin
         grant = (last == OWN_D) ? OWN_I : OWN_D;
      end else if (d_req) begin
         grant = OWN_D;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises instruction-fetch and data accesses onto one fixed-latency,
// single-port memory and returns read data with per-port acks and stalls.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int MEM_LAT = 1,
   parameter int AW      = 32,
   parameter int DW      = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_ack,
   output logic [DW-1:0] if_rdata,
   output logic          if_stall,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_ack,
   output logic [DW-1:0] d_rdata,
   output logic          d_stall,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   arb_state_t       state;
   owner_t           owner;
   owner_t           last;
   logic [CNT_W-1:0] cnt;
   owner_t           pick;
   logic             pick_valid;

   rr_pick u_pick (
      .if_req (if_req),
      .d_req  (d_req),
      .last   (last),
      .grant  (pick),
      .valid  (pick_valid)
   );

   // Stalls follow the live request and the registered ack with no delay.
   assign if_stall = if_req & ~if_ack;
   assign d_stall  = d_req & ~d_ack;

   // Arbitration, command issue, latency count and read-data capture.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         owner     <= OWN_I;
         last      <= OWN_I;
         cnt       <= '0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_ack    <= 1'b0;
         d_ack     <= 1'b0;
         if_rdata  <= '0;
         d_rdata   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (pick_valid) begin
                  mem_en <= 1'b1;
                  owner  <= pick;
                  last   <= pick;
                  cnt    <= CNT_W'(MEM_LAT);
                  state  <= WAIT;
                  if (pick == OWN_D) begin
                     mem_we    <= d_we;
                     mem_addr  <= d_addr;
                     mem_wdata <= d_wdata;
                  end else begin
                     mem_we   <= 1'b0;
                     mem_addr <= if_addr;
                  end
               end
            end
            WAIT: begin
               // The strobe cycle itself does not count: data arrives
               // MEM_LAT cycles after it, so cnt starts ticking one later.
               if (mem_en) begin
                  mem_en <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
                  if (cnt == CNT_W'(1)) begin
                     state <= DONE;
                     if (owner == OWN_D) begin
                        d_rdata <= mem_rdata;
                        d_ack   <= 1'b1;
                     end else begin
                        if_rdata <= mem_rdata;
                        if_ack   <= 1'b1;
                     end
                  end
               end
            end
            DONE: begin
               if_ack <= 1'b0;
               d_ack  <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: two instances (MEM_LAT 1 and 4)
// share the request inputs, each with its own behavioural memory.
module tb_mem_arbiter;

   localparam int LA = 1;
   localparam int LB = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req, d_req, d_we;
   logic [31:0] if_addr, d_addr, d_wdata;

   logic        a_if_ack, a_if_stall, a_d_ack, a_d_stall, a_mem_en, a_mem_we;
   logic [31:0] a_if_rdata, a_d_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
   logic        b_if_ack, b_if_stall, b_d_ack, b_d_stall, b_mem_en, b_mem_we;
   logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.MEM_LAT(LA), .AW(32), .DW(32)) u_dut_a (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_ack(a_if_ack),
      .if_rdata(a_if_rdata), .if_stall(a_if_stall),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(a_d_ack), .d_rdata(a_d_rdata), .d_stall(a_d_stall),
      .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
      .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
   );

   mem_arbiter #(.MEM_LAT(LB), .AW(32), .DW(32)) u_dut_b (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_ack(b_if_ack),
      .if_rdata(b_if_rdata), .if_stall(b_if_stall),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(b_d_ack), .d_rdata(b_d_rdata), .d_stall(b_d_stall),
      .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
      .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
   );

   // Contents of a never-written word.
   function automatic logic [31:0] init_word(input logic [31:0] a);
      if (a == 32'h40) return 32'h20080005;
      return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
   endfunction

   // Memory models: data is driven only exactly LAT cycles after a strobe,
   // random junk otherwise.
   bit          ha_en[16], hb_en[16];
   logic [31:0] ha_ad[16], hb_ad[16];
   logic [31:0] ma[512], mb[512];
   bit          wa[512], wb[512];
   logic [31:0] junk_a, junk_b;

   always @(posedge clk) begin
      ha_en[1] <= a_mem_en;
      ha_ad[1] <= a_mem_addr;
      hb_en[1] <= b_mem_en;
      hb_ad[1] <= b_mem_addr;
      for (int k = 2; k < 16; k++) begin
         ha_en[k] <= ha_en[k-1];
         ha_ad[k] <= ha_ad[k-1];
         hb_en[k] <= hb_en[k-1];
         hb_ad[k] <= hb_ad[k-1];
      end
      if (a_mem_en && a_mem_we) begin
         ma[a_mem_addr[10:2]] <= a_mem_wdata;
         wa[a_mem_addr[10:2]] <= 1'b1;
      end
      if (b_mem_en && b_mem_we) begin
         mb[b_mem_addr[10:2]] <= b_mem_wdata;
         wb[b_mem_addr[10:2]] <= 1'b1;
      end
      junk_a <= $urandom;
      junk_b <= $urandom;
   end

   assign a_mem_rdata = ha_en[LA] ? (wa[ha_ad[LA][10:2]] ? ma[ha_ad[LA][10:2]]
                                                         : init_word(ha_ad[LA])) : junk_a;
   assign b_mem_rdata = hb_en[LB] ? (wb[hb_ad[LB][10:2]] ? mb[hb_ad[LB][10:2]]
                                                         : init_word(hb_ad[LB])) : junk_b;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      if_req = 1'b0;
      d_req  = 1'b0;
      d_we   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      logic [4:0] got;
      do_reset();
      n_cmp++;
      got = {a_mem_en, a_if_ack, a_d_ack, b_mem_en, b_d_ack};
      if (got !== 5'b0) begin
         n_bad++;
         $display("FAIL reset_idle: got %b want 00000", got);
      end
      d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'h12345678; d_req = 1'b1;
      if_addr = 32'h304; if_req = 1'b1;
      repeat (6) step();
      #1;
      reset = 1'b1; if_req = 1'b0; d_req = 1'b0;
      #1;
      n_cmp++;
      if ({a_if_ack, a_d_ack, a_mem_en, a_mem_we, a_if_stall, a_d_stall,
           a_mem_addr, a_mem_wdata, a_if_rdata, a_d_rdata} !== 134'b0 ||
          {b_if_ack, b_d_ack, b_mem_en, b_mem_we, b_if_stall, b_d_stall,
           b_mem_addr, b_mem_wdata, b_if_rdata, b_d_rdata} !== 134'b0) begin
         n_bad++;
         $display("FAIL reset_values: a addr=%h wdata=%h en=%b ack=%b%b, b addr=%h en=%b, want all 0",
                  a_mem_addr, a_mem_wdata, a_mem_en, a_if_ack, a_d_ack, b_mem_addr, b_mem_en);
      end
      do_reset();
   endtask

   task automatic test_single_fetch();
      logic [3:0] got, exp;
      do_reset();
      if_addr = 32'h40; if_req = 1'b1;
      for (int k = 0; k < 5; k++) begin
         if (k == 4) if_req = 1'b0;
         @(negedge clk);
         n_cmp++;
         got = {a_mem_en, a_if_ack, a_d_ack, a_if_stall};
         exp = {k == 1, k == 3, 1'b0, k <= 2};
         if (got !== exp) begin
            n_bad++;
            $display("FAIL fetch_ctl cyc%0d: en/iack/dack/istall got %b want %b", k, got, exp);
         end
         if (k == 1) begin
            n_cmp++;
            if (a_mem_addr !== 32'h40 || a_mem_we !== 1'b0) begin
               n_bad++;
               $display("FAIL fetch_cmd: addr=%h we=%b want 00000040/0", a_mem_addr, a_mem_we);
            end
         end
         if (k == 3) begin
            n_cmp++;
            if (a_if_rdata !== 32'h20080005) begin
               n_bad++;
               $display("FAIL fetch_data: got %h want 20080005", a_if_rdata);
            end
         end
         step();
      end
   endtask

   task automatic test_simultaneous();
      logic [4:0] got, exp;
      do_reset();
      if_addr = 32'h48; if_req = 1'b1;
      d_addr = 32'h100; d_we = 1'b0; d_req = 1'b1;
      for (int k = 0; k < 9; k++) begin
         if (k == 4) d_req = 1'b0;
         if (k == 8) if_req = 1'b0;
         @(negedge clk);
         n_cmp++;
         got = {a_mem_en, a_d_ack, a_if_ack, a_d_stall, a_if_stall};
         exp = {k == 1 || k == 5, k == 3, k == 7, k <= 2, k <= 6};
         if (got !== exp) begin
            n_bad++;
            $display("FAIL simul_ctl cyc%0d: en/dack/iack/dst/ist got %b want %b", k, got, exp);
         end
         if (k == 1 || k == 5) begin
            n_cmp++;
            if (a_mem_addr !== ((k == 1) ? 32'h100 : 32'h48)) begin
               n_bad++;
               $display("FAIL simul_addr cyc%0d: got %h", k, a_mem_addr);
            end
         end
         if (k == 3) begin
            n_cmp++;
            if (a_d_rdata !== init_word(32'h100)) begin
               n_bad++;
               $display("FAIL simul_ddata: got %h want %h", a_d_rdata, init_word(32'h100));
            end
         end
         if (k == 7) begin
            n_cmp++;
            if (a_if_rdata !== init_word(32'h48)) begin
               n_bad++;
               $display("FAIL simul_idata: got %h want %h", a_if_rdata, init_word(32'h48));
            end
         end
         step();
      end
   endtask

   task automatic test_store();
      logic [2:0] got, exp;
      do_reset();
      d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'hDEADBEEF; d_req = 1'b1;
      for (int k = 0; k < 10; k++) begin
         if (k == 4) d_req = 1'b0;
         if (k == 5) begin d_we = 1'b0; d_wdata = 32'h0; d_req = 1'b1; end
         if (k == 9) d_req = 1'b0;
         @(negedge clk);
         n_cmp++;
         got = {a_mem_en, a_d_ack, a_if_ack};
         exp = {k == 1 || k == 6, k == 3 || k == 8, 1'b0};
         if (got !== exp) begin
            n_bad++;
            $display("FAIL store_ctl cyc%0d: en/dack/iack got %b want %b", k, got, exp);
         end
         if (k == 1) begin
            n_cmp++;
            if ({a_mem_we, a_mem_addr, a_mem_wdata} !== {1'b1, 32'h80, 32'hDEADBEEF}) begin
               n_bad++;
               $display("FAIL store_cmd: we=%b addr=%h wdata=%h want 1/80/deadbeef",
                        a_mem_we, a_mem_addr, a_mem_wdata);
            end
         end
         if (k == 8) begin
            n_cmp++;
            if (a_d_rdata !== 32'hDEADBEEF) begin
               n_bad++;
               $display("FAIL store_readback: got %h want deadbeef", a_d_rdata);
            end
         end
         step();
      end
   endtask

   task automatic test_latency();
      logic [2:0] got, exp;
      do_reset();
      d_we = 1'b0; d_addr = 32'h200; d_req = 1'b1;
      for (int k = 0; k < 8; k++) begin
         if (k == 7) d_req = 1'b0;
         @(negedge clk);
         n_cmp++;
         got = {b_mem_en, b_d_ack, b_d_stall};
         exp = {k == 1, k == 6, k <= 5};
         if (got !== exp) begin
            n_bad++;
            $display("FAIL lat4_ctl cyc%0d: en/dack/dst got %b want %b", k, got, exp);
         end
         if (k == 6) begin
            n_cmp++;
            if (b_d_rdata !== init_word(32'h200)) begin
               n_bad++;
               $display("FAIL lat4_data: got %h want %h", b_d_rdata, init_word(32'h200));
            end
         end
         step();
      end
   endtask

   task automatic test_fairness();
      logic [1:0] got, exp;
      bit         ack_slot, d_turn;
      do_reset();
      if_addr = 32'h60; if_req = 1'b1;
      d_addr = 32'h64; d_we = 1'b0; d_req = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         ack_slot = (k % 4) == 3;
         d_turn   = ((k / 4) % 2) == 0;
         n_cmp++;
         got = {a_d_ack, a_if_ack};
         exp = {ack_slot && d_turn, ack_slot && !d_turn};
         if (got !== exp) begin
            n_bad++;
            $display("FAIL fair_order cyc%0d: dack/iack got %b want %b", k, got, exp);
         end
         if (ack_slot) begin
            n_cmp++;
            if ((d_turn ? a_d_rdata : a_if_rdata) !== init_word(d_turn ? 32'h64 : 32'h60)) begin
               n_bad++;
               $display("FAIL fair_data cyc%0d: d=%h i=%h", k, a_d_rdata, a_if_rdata);
            end
         end
         step();
      end
      if_req = 1'b0; d_req = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [2:0] got, exp;
      do_reset();
      d_we = 1'b0; d_addr = 32'h204; d_req = 1'b1;
      step();
      step();
      #1;
      reset = 1'b1; d_req = 1'b0;
      #1;
      n_cmp++;
      if ({b_if_ack, b_d_ack, b_mem_en, b_mem_we, b_if_stall, b_d_stall,
           b_mem_addr, b_mem_wdata, b_if_rdata, b_d_rdata} !== 134'b0) begin
         n_bad++;
         $display("FAIL midreset_zero: en=%b ack=%b%b addr=%h want all 0",
                  b_mem_en, b_if_ack, b_d_ack, b_mem_addr);
      end
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         n_cmp++;
         if ({b_mem_en, b_if_ack, b_d_ack} !== 3'b0) begin
            n_bad++;
            $display("FAIL midreset_quiet cyc%0d: en/iack/dack got %b want 000",
                     k, {b_mem_en, b_if_ack, b_d_ack});
         end
         step();
      end
      if_addr = 32'h44; if_req = 1'b1;
      for (int k = 0; k < 8; k++) begin
         if (k == 7) if_req = 1'b0;
         @(negedge clk);
         n_cmp++;
         got = {b_mem_en, b_if_ack, b_d_ack};
         exp = {k == 1, k == 6, 1'b0};
         if (got !== exp) begin
            n_bad++;
            $display("FAIL midreset_after cyc%0d: en/iack/dack got %b want %b", k, got, exp);
         end
         if (k == 6) begin
            n_cmp++;
            if (b_if_rdata !== init_word(32'h44)) begin
               n_bad++;
               $display("FAIL midreset_data: got %h want %h", b_if_rdata, init_word(32'h44));
            end
         end
         step();
      end
   endtask

   // Transaction-level model: one access at a time, LA+3 cycles each,
   // tie broken against the previous winner.
   task automatic test_random();
      int unsigned busy, ack_at;
      bit          own_d, last_d, ack_valid, exp_store, g_d, drop_i, drop_d;
      bit          exp_ia, exp_da;
      logic [31:0] exp_data, addr;
      logic [31:0] mm[512];
      bit          mw[512];
      logic [3:0]  got, exp;
      do_reset();
      busy = 0; last_d = 1'b0; ack_valid = 1'b0; own_d = 1'b0; ack_at = 0;
      exp_store = 1'b0; exp_data = '0;
      for (int unsigned c = 0; c < 600; c++) begin
         drop_i = 1'b0; drop_d = 1'b0;
         if (ack_valid && c == ack_at + 1) begin
            if (own_d) begin d_req = 1'b0; drop_d = 1'b1; end
            else begin if_req = 1'b0; drop_i = 1'b1; end
         end
         if (!if_req && !drop_i && $urandom_range(0, 3) == 0) begin
            if_req  = 1'b1;
            if_addr = 32'h400 + ($urandom_range(0, 255) << 2);
         end
         if (!d_req && !drop_d && $urandom_range(0, 3) == 0) begin
            d_req   = 1'b1;
            d_we    = $urandom_range(0, 1) == 1;
            d_addr  = 32'h400 + ($urandom_range(0, 255) << 2);
            d_wdata = $urandom;
         end
         if (c == busy) begin
            if (if_req || d_req) begin
               g_d       = d_req && (!if_req || !last_d);
               last_d    = g_d;
               own_d     = g_d;
               ack_at    = c + LA + 2;
               busy      = c + LA + 3;
               ack_valid = 1'b1;
               addr      = g_d ? d_addr : if_addr;
               if (g_d && d_we) begin
                  mm[addr[10:2]] = d_wdata;
                  mw[addr[10:2]] = 1'b1;
                  exp_store = 1'b1;
               end else begin
                  exp_data  = mw[addr[10:2]] ? mm[addr[10:2]] : init_word(addr);
                  exp_store = 1'b0;
               end
            end else begin
               busy = c + 1;
            end
         end
         @(negedge clk);
         exp_ia = ack_valid && c == ack_at && !own_d;
         exp_da = ack_valid && c == ack_at && own_d;
         n_cmp++;
         got = {a_if_ack, a_d_ack, a_if_stall, a_d_stall};
         exp = {exp_ia, exp_da, if_req & ~exp_ia, d_req & ~exp_da};
         if (got !== exp) begin
            n_bad++;
            $display("FAIL rand_ctl cyc%0d: iack/dack/ist/dst got %b want %b", c, got, exp);
         end
         if (exp_ia || (exp_da && !exp_store)) begin
            n_cmp++;
            if ((exp_ia ? a_if_rdata : a_d_rdata) !== exp_data) begin
               n_bad++;
               $display("FAIL rand_data cyc%0d: got %h want %h", c,
                        exp_ia ? a_if_rdata : a_d_rdata, exp_data);
            end
         end
         step();
      end
      if_req = 1'b0; d_req = 1'b0;
   endtask

   initial begin
      reset = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      if_addr = '0; d_addr = '0; d_wdata = '0;
      test_reset();
      test_single_fetch();
      test_simultaneous();
      test_store();
      test_latency();
      test_fairness();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
